// File: rtl/multi_signal_generator.sv
// Multi-channel tick divider: every channel counts rising edges of a shared tick
// strobe and drives a continuous, one-shot or toggling pulse train.
module multi_signal_generator #(
  parameter int CHANNELS       = 4,
  parameter int CH_W           = 2,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 2,
  parameter int DEFAULT_WIDTH  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [1:0]          cfg_mode,
  input  logic [CHANNELS-1:0] ch_enable,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] done,
  output logic                busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_CONT    = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  localparam logic [1:0] MODE_TOGGLE  = 2'd3;

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_WIDTH  = CNT_W'(DEFAULT_WIDTH);

  logic                tick_q;
  logic                tick_rise;
  logic [CHANNELS-1:0] next_run;

  assign tick_rise = tick & ~tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      busy   <= 1'b0;
    end else begin
      tick_q <= tick;
      busy   <= |next_run;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] period, period_nxt;
    logic [CNT_W-1:0] width, width_nxt;
    logic [1:0]       mode, mode_nxt;
    logic             out_q, out_nxt;
    logic             done_q, done_nxt;
    logic [CNT_W-1:0] p_eff, w_eff;
    logic             wrap, wr_hit, run_ok;

    assign wr_hit = cfg_we && (int'(cfg_ch) == i);
    assign p_eff  = (period == '0) ? CNT_W'(1) : period;
    assign w_eff  = (width > p_eff) ? p_eff : width;
    assign wrap   = (count == p_eff - CNT_W'(1));
    assign run_ok = ch_enable[i] && (mode != MODE_OFF);

    // The output reflects the position of the tick just counted: high for the
    // last W ticks of each period, so it uses the counter value before the step.
    always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      period_nxt = period;
      width_nxt  = width;
      mode_nxt   = mode;
      out_nxt    = out_q;
      done_nxt   = 1'b0;
      if (wr_hit) begin
        period_nxt = cfg_period;
        width_nxt  = cfg_width;
        mode_nxt   = cfg_mode;
        count_nxt  = '0;
        out_nxt    = 1'b0;
        state_nxt  = (ch_enable[i] && cfg_mode != MODE_OFF) ? ST_RUN : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            out_nxt = 1'b0;
            if (run_ok) begin
              state_nxt = ST_RUN;
              count_nxt = '0;
            end
          end
          ST_RUN: begin
            if (!run_ok) begin
              state_nxt = ST_IDLE;
              count_nxt = '0;
              out_nxt   = 1'b0;
            end else if (tick_rise) begin
              count_nxt = wrap ? '0 : count + CNT_W'(1);
              if (mode == MODE_TOGGLE) begin
                if (wrap) out_nxt = ~out_q;
              end else begin
                out_nxt = (count >= p_eff - w_eff);
              end
              if (mode == MODE_ONESHOT && wrap) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
              end
            end
          end
          ST_DONE: begin
            out_nxt = 1'b0;
            if (!run_ok) begin
              state_nxt = ST_IDLE;
              count_nxt = '0;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
            out_nxt   = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= ST_IDLE;
        count  <= '0;
        period <= RST_PERIOD;
        width  <= RST_WIDTH;
        mode   <= MODE_CONT;
        out_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        count  <= count_nxt;
        period <= period_nxt;
        width  <= width_nxt;
        mode   <= mode_nxt;
        out_q  <= out_nxt;
        done_q <= done_nxt;
      end
    end

    assign out[i]      = out_q;
    assign done[i]     = done_q;
    assign next_run[i] = (state_nxt == ST_RUN);
  end

endmodule
